reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of architectural registers tracked.
REQ-002 SHALL have parameter ADDR_W, default 4: register address width.
REQ-003 SHALL have parameter CNT_W, default 2: per-register pending-write counter width; maximum count is 2^CNT_W-1.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port id_valid, input, 1: an instruction is in decode requesting issue.
REQ-007 SHALL have port src1, input, ADDR_W: first source register of the decode instruction.
REQ-008 SHALL have port src2, input, ADDR_W: second source register of the decode instruction.
REQ-009 SHALL have port use_src2, input, 1: src2 is a real operand; ignore src2 when 0.
REQ-010 SHALL have port id_wb_en, input, 1: the decode instruction writes a register.
REQ-011 SHALL have port id_dest, input, ADDR_W: destination register of the decode instruction.
REQ-012 SHALL have port flush, input, 1: the decode instruction is squashed this cycle.
REQ-013 SHALL have port wb_en, input, 1: the write-back stage writes the register file this cycle.
REQ-014 SHALL have port wb_dest, input, ADDR_W: the write-back destination register.
REQ-015 SHALL have port stall, output, 1: the decode instruction must hold; combinational.
REQ-016 SHALL have port pending, output, NUM_REGS: bit r is 1 when count[r] != 0; registered.
REQ-017 SHALL have port err, output, 1: sticky flag for underflow or overflow; registered.

Function
REQ-018 SHALL keep one CNT_W-bit counter count[r] per register, giving the number of issued, not-yet-written-back writes to r.
REQ-019 SHALL define dec[r] = wb_en && wb_dest==r.
REQ-020 SHALL define busy(r) = (count[r] - dec[r]) != 0. A write-back in the same cycle resolves the hazard because the register file writes on negedge before the decode read.
REQ-021 SHALL define full = id_wb_en && (count[id_dest] - dec[id_dest]) == 2^CNT_W-1.
REQ-022 SHALL drive stall = id_valid && !flush && (busy(src1) || (use_src2 && busy(src2)) || full).
REQ-023 SHALL define issue = id_valid && !flush && !stall && id_wb_en.
REQ-024 SHALL update each register as count[r] <= count[r] + (issue && id_dest==r) - dec[r].
- Simultaneous increment and decrement on the same r leaves count unchanged.
REQ-025 SHALL treat dec[r] with count[r]==0 and no simultaneous increment on r as underflow: count stays 0 and err is set to 1.
REQ-026 SHALL never wrap a counter above its maximum. The full stall prevents overflow.
- Any attempted overflow (defensive check) holds the count and sets err.
REQ-027 SHALL keep err at 1 once set, until reset.
REQ-028 SHALL register pending[r] = (next count[r] != 0), so pending matches the counters one cycle after each update.
REQ-029 SHALL make flush suppress only the current decode instruction.
- In-flight counts are never cleared by flush; squashed-path instructions never issued.
REQ-030 SHALL have zero-cycle stall latency: stall reflects the current-cycle inputs and state.
REQ-031 SHALL not check for a hazard on id_dest (WAW). Ordering is preserved by in-order write-back.

Reset
REQ-032 SHALL, on rst asserted, asynchronously clear all count[r], pending and err to 0.
REQ-033 SHALL produce stall=0 while rst is high.
REQ-034 SHALL discard in-flight state on reset mid-operation.
- Write-backs arriving after reset release with count 0 are underflows and set err.

Verification
REQ-035 SHALL cover RAW stall: issue dest=R3; next cycle id_valid src1=R3 with no wb -> stall=1, pending[3]=1; assert wb_en wb_dest=3 -> stall=0 in that same cycle; pending[3]=0 the next cycle.
REQ-036 SHALL cover same-cycle inc+dec: count[5]=1; issue dest=5 while wb_dest=5 -> count[5] stays 1, pending[5]=1, err=0.
REQ-037 SHALL cover saturation with CNT_W=2: three issues to R7 without write-back -> fourth issue to R7 stalls (full); one wb to R7 in the same cycle -> fourth issues, count[7]=3.
REQ-038 SHALL cover flush: id_valid=1 flush=1 id_wb_en=1 dest=R2 with src1 busy -> stall=0, count[2] unchanged, pending[2]=0.
REQ-039 SHALL cover underflow: wb_en=1 wb_dest=9 with count[9]=0 -> count[9]=0, err=1 next cycle, err still 1 after 10 further idle cycles.
REQ-040 SHALL cover async reset mid-operation: pending=16'h00F0; pulse rst between clock edges -> pending=0 and err=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that drive the
// decode-stage RAW/full stall and a sticky underflow/overflow error flag.

// One pending-write counter plus its registered nonzero flag.
module reg_scoreboard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             pend,
    output logic             bad
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;

    // Next count: inc+dec cancel; saturate at both ends and flag the attempt.
    always_comb begin
        cnt_d = cnt_q;
        bad   = 1'b0;
        unique case ({inc, dec})
            2'b10: begin
                if (cnt_q == CNT_MAX) bad = 1'b1;
                else                  cnt_d = cnt_q + CNT_W'(1);
            end
            2'b01: begin
                if (cnt_q == '0) bad = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            default: cnt_d = cnt_q;
        endcase
        pend_d = (cnt_d != '0);
    end

    // Counter and pending flag; async clear discards in-flight writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign cnt  = cnt_q;
    assign pend = pend_q;
endmodule

module reg_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [ADDR_W-1:0]   src1,
    input  logic [ADDR_W-1:0]   src2,
    input  logic                use_src2,
    input  logic                id_wb_en,
    input  logic [ADDR_W-1:0]   id_dest,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_dest,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic                err
);
    localparam int               SPAN    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            dec_vec, inc_vec, busy_vec, top_vec;
    logic [NUM_REGS-1:0]            pend_vec, bad_vec;
    logic [SPAN-1:0]                busy_ext, top_ext;
    logic                           src_hit, full, issue;
    logic                           err_q, err_d;

    // Per-register decode of write-back/issue and the hazard terms.
    // A same-cycle write-back clears the hazard: the register file writes
    // on negedge ahead of the decode read.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        assign dec_vec[r]  = wb_en && (wb_dest == ADDR_W'(r));
        assign inc_vec[r]  = issue && (id_dest == ADDR_W'(r));
        assign busy_vec[r] = (cnt[r] != CNT_W'(dec_vec[r]));
        assign top_vec[r]  = (cnt[r] == CNT_MAX) && !dec_vec[r];

        reg_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc_vec[r]),
            .dec  (dec_vec[r]),
            .cnt  (cnt[r]),
            .pend (pend_vec[r]),
            .bad  (bad_vec[r])
        );
    end

    // Widen to the full address space so any address indexes safely;
    // unimplemented registers never report busy or full.
    always_comb begin
        busy_ext                 = '0;
        top_ext                  = '0;
        busy_ext[NUM_REGS-1:0]   = busy_vec;
        top_ext[NUM_REGS-1:0]    = top_vec;
    end

    // Zero-latency stall and issue decision for the decode instruction.
    // No WAW check on id_dest: in-order write-back keeps ordering.
    always_comb begin
        src_hit = busy_ext[src1] || (use_src2 && busy_ext[src2]);
        full    = id_wb_en && top_ext[id_dest];
        stall   = !rst && id_valid && !flush && (src_hit || full);
        issue   = id_valid && !flush && !stall && id_wb_en;
        err_d   = err_q || (|bad_vec);
    end

    // Sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign pending = pend_vec;
    assign err     = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized + directed bench for reg_scoreboard with an integer-count model.
module tb_reg_scoreboard;
    localparam int NR = 16, AW = 4, CW = 2, MAXC = 3;

    logic          clk = 1'b0, rst = 1'b1;
    logic          id_valid = 0, use_src2 = 0, id_wb_en = 0, flush = 0, wb_en = 0;
    logic [AW-1:0] src1 = 0, src2 = 0, id_dest = 0, wb_dest = 0;
    logic          stall, err;
    logic [NR-1:0] pending;

    int  m_cnt [NR];
    bit  m_err;
    int  n_checks = 0, n_err = 0;
    bit  cmp_en = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .use_src2(use_src2), .id_wb_en(id_wb_en), .id_dest(id_dest),
        .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
        .stall(stall), .pending(pending), .err(err)
    );

    function automatic int m_dec(int r);
        return (wb_en && int'(wb_dest) == r) ? 1 : 0;
    endfunction

    function automatic bit m_busy(int r);
        return (m_cnt[r] - m_dec(r)) != 0;
    endfunction

    function automatic bit m_stall();
        if (rst || !id_valid || flush) return 1'b0;
        return m_busy(int'(src1)) || (use_src2 && m_busy(int'(src2))) ||
               (id_wb_en && (m_cnt[int'(id_dest)] - m_dec(int'(id_dest))) == MAXC);
    endfunction

    function automatic logic [NR-1:0] m_pend();
        logic [NR-1:0] p;
        p = '0;
        for (int r = 0; r < NR; r++) p[r] = (m_cnt[r] != 0);
        return p;
    endfunction

    // Reference model: integer counts per register, saturating at 0 and MAXC.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) m_cnt[i] <= 0;
            m_err <= 1'b0;
        end else begin : upd
            automatic int nc [NR];
            automatic bit e;
            automatic bit iss;
            automatic bit inc;
            automatic int d;
            e   = m_err;
            iss = id_valid && !flush && !m_stall() && id_wb_en;
            for (int r = 0; r < NR; r++) begin
                inc   = iss && (int'(id_dest) == r);
                d     = m_dec(r);
                nc[r] = m_cnt[r];
                if (inc && d == 0) begin
                    if (m_cnt[r] == MAXC) e = 1'b1;
                    else                  nc[r] = m_cnt[r] + 1;
                end else if (!inc && d == 1) begin
                    if (m_cnt[r] == 0) e = 1'b1;
                    else               nc[r] = m_cnt[r] - 1;
                end
            end
            m_cnt <= nc;
            m_err <= e;
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall", 32'(stall), 32'(m_stall()));
            check("pending", 32'(pending), 32'(m_pend()));
            check("err", 32'(err), 32'(m_err));
        end
    end

    task automatic drive(logic v, logic [AW-1:0] s1, logic [AW-1:0] s2, logic u2,
                         logic we, logic [AW-1:0] d, logic fl, logic wbe,
                         logic [AW-1:0] wbd);
        @(posedge clk);
        #2;
        id_valid = v; src1 = s1; src2 = s2; use_src2 = u2; id_wb_en = we;
        id_dest = d; flush = fl; wb_en = wbe; wb_dest = wbd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue_to(logic [AW-1:0] d);
        drive(1, 0, 0, 0, 1, d, 0, 0, 0);
    endtask

    task automatic wb_to(logic [AW-1:0] d);
        drive(0, 0, 0, 0, 0, 0, 0, 1, d);
    endtask

    initial begin
        #2;
        cmp_en = 1;
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        @(posedge clk); #2 rst = 0;

        // RAW stall resolved by same-cycle write-back
        issue_to(3);
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
        #1 check("raw_stall", 32'(stall), 32'h1);
        check("raw_pending3", 32'(pending[3]), 32'h1);
        drive(1, 3, 0, 0, 0, 0, 0, 1, 3);
        #1 check("raw_wb_bypass", 32'(stall), 32'h0);
        idle();
        #1 check("raw_pending3_clr", 32'(pending[3]), 32'h0);

        // simultaneous inc+dec on R5
        issue_to(5);
        drive(1, 0, 0, 0, 1, 5, 0, 1, 5);
        idle();
        #1 check("incdec_pending5", 32'(pending[5]), 32'h1);
        check("incdec_err", 32'(err), 32'h0);
        wb_to(5);

        // saturation on R7
        issue_to(7); issue_to(7); issue_to(7);
        issue_to(7);
        #1 check("full_stall", 32'(stall), 32'h1);
        drive(1, 0, 0, 0, 1, 7, 0, 1, 7);
        #1 check("full_wb_issue", 32'(stall), 32'h0);
        wb_to(7); wb_to(7);
        idle();
        #1 check("sat_pending7_two_wb", 32'(pending[7]), 32'h1);
        wb_to(7);
        idle();
        #1 check("sat_pending7_drain", 32'(pending[7]), 32'h0);
        check("sat_err", 32'(err), 32'h0);

        // flush squashes a would-stall instruction
        issue_to(4);
        drive(1, 4, 0, 0, 1, 2, 1, 0, 0);
        #1 check("flush_stall", 32'(stall), 32'h0);
        idle();
        #1 check("flush_pending2", 32'(pending[2]), 32'h0);
        wb_to(4);

        // underflow is sticky
        wb_to(9);
        idle();
        #1 check("unf_err", 32'(err), 32'h1);
        check("unf_pending9", 32'(pending[9]), 32'h0);
        repeat (10) idle();
        #1 check("unf_err_sticky", 32'(err), 32'h1);

        // async reset mid-operation
        issue_to(4); issue_to(5); issue_to(6); issue_to(7);
        idle();
        #1 check("pre_rst_pending", 32'(pending), 32'h00F0);
        rst = 1;
        #1 check("async_rst_pending", 32'(pending), 32'h0);
        check("async_rst_err", 32'(err), 32'h0);
        @(posedge clk); #2 rst = 0;
        wb_to(4);
        idle();
        #1 check("post_rst_unf", 32'(err), 32'h1);

        // randomized traffic
        @(posedge clk); #3 rst = 1;
        @(posedge clk); #2 rst = 0;
        for (int n = 0; n < 2000; n++) begin : rnd
            automatic logic [AW-1:0] wbd;
            automatic int st;
            wbd = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 85) begin
                st = $urandom_range(0, NR - 1);
                for (int k = 0; k < NR; k++)
                    if (m_cnt[(st + k) % NR] != 0) begin
                        wbd = AW'((st + k) % NR);
                        break;
                    end
            end
            drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)),
                  $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), wbd);
            if ($urandom_range(0, 149) == 0) begin
                #1 rst = 1;
                @(posedge clk); #2 rst = 0;
            end
        end

        idle();
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
